// File: rtl/axi_read_responder.sv
// AXI-4 read slave over an internal word-addressed RAM: one AR holding register, an INCR burst
// engine, a registered RAM read stage and a two-entry output skid buffer on the R channel.
module axi_read_responder #(
  parameter int unsigned DataIndexSize = 4,
  parameter int unsigned AxiIdWidth    = 4,
  parameter int unsigned MemIndexSize  = 10,
  localparam int unsigned DataWidth    = (1 << DataIndexSize) * 8
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    axiARValid,
  output logic                    axiARReady,
  input  logic [AxiIdWidth-1:0]   axiARId,
  input  logic [63:0]             axiARAddr,
  input  logic [7:0]              axiARLen,
  input  logic [2:0]              axiARSize,
  output logic                    axiRValid,
  input  logic                    axiRReady,
  output logic [AxiIdWidth-1:0]   axiRId,
  output logic [DataWidth-1:0]    axiRData,
  output logic [1:0]              axiRResp,
  output logic                    axiRLast,
  input  logic                    memWriteEnable,
  input  logic [MemIndexSize-1:0] memWriteAddr,
  input  logic [DataWidth-1:0]    memWriteData
);

  localparam int unsigned MemDepth = 1 << MemIndexSize;

  typedef enum logic [0:0] {EngIdle, EngBurst} engState_e;

  // AR holding register
  logic                  arReadyEnQ;
  logic                  holdValidQ;
  logic [AxiIdWidth-1:0] holdIdQ;
  logic [63:0]           holdWordQ;
  logic [7:0]            holdLeftQ;
  logic                  holdSizeErrQ;
  logic                  arFire;
  logic                  holdTake;

  // Burst engine
  engState_e             engStateQ, engStateD;
  logic [AxiIdWidth-1:0] engIdQ, engIdD;
  logic [63:0]           engWordQ, engWordD;
  logic [7:0]            engLeftQ, engLeftD;
  logic                  engSizeErrQ, engSizeErrD;

  // Beat source: the engine when busy, otherwise the holding register directly
  logic                  engActive;
  logic                  srcValid;
  logic [AxiIdWidth-1:0] srcId;
  logic [63:0]           srcWord;
  logic [7:0]            srcLeft;
  logic                  srcSizeErr;
  logic                  srcRangeErr;
  logic                  srcLastBeat;
  logic                  issue;

  // RAM read stage
  logic [DataWidth-1:0]  mem [MemDepth];
  logic                  aValidQ;
  logic [AxiIdWidth-1:0] aIdQ;
  logic                  aErrQ;
  logic                  aLastQ;
  logic [DataWidth-1:0]  aDataQ;
  logic                  aAdvance;
  logic [DataWidth-1:0]  inData;
  logic [1:0]            inResp;

  // Output register and skid entry
  logic                  outValidQ;
  logic [AxiIdWidth-1:0] outIdQ;
  logic [DataWidth-1:0]  outDataQ;
  logic [1:0]            outRespQ;
  logic                  outLastQ;
  logic                  skidValidQ;
  logic [AxiIdWidth-1:0] skidIdQ;
  logic [DataWidth-1:0]  skidDataQ;
  logic [1:0]            skidRespQ;
  logic                  skidLastQ;

  assign axiARReady = arReadyEnQ & ~holdValidQ;
  assign arFire     = axiARValid & axiARReady;

  always_ff @(posedge clk) begin
    if (srst) begin
      arReadyEnQ <= 1'b0;
      holdValidQ <= 1'b0;
    end else begin
      arReadyEnQ <= 1'b1;
      if (arFire) begin
        holdValidQ <= 1'b1;
      end else if (holdTake) begin
        holdValidQ <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arFire) begin
      holdIdQ      <= axiARId;
      holdWordQ    <= axiARAddr >> DataIndexSize;
      holdLeftQ    <= axiARLen;
      holdSizeErrQ <= (axiARSize != 3'(DataIndexSize));
    end
  end

  assign engActive   = (engStateQ == EngBurst);
  assign srcValid    = engActive | holdValidQ;
  assign srcId       = engActive ? engIdQ : holdIdQ;
  assign srcWord     = engActive ? engWordQ : holdWordQ;
  assign srcLeft     = engActive ? engLeftQ : holdLeftQ;
  assign srcSizeErr  = engActive ? engSizeErrQ : holdSizeErrQ;
  assign srcRangeErr = |srcWord[63:MemIndexSize];
  assign srcLastBeat = (srcLeft == 8'd0);
  // Issue only when the read stage is empty or is draining into the skid buffer this cycle.
  assign issue       = srcValid & (~aValidQ | ~skidValidQ);

  always_comb begin
    engStateD   = engStateQ;
    engIdD      = engIdQ;
    engWordD    = engWordQ;
    engLeftD    = engLeftQ;
    engSizeErrD = engSizeErrQ;
    holdTake    = 1'b0;
    unique case (engStateQ)
      EngIdle: begin
        if (holdValidQ) begin
          holdTake    = 1'b1;
          engIdD      = holdIdQ;
          engSizeErrD = holdSizeErrQ;
          if (issue) begin
            engWordD = holdWordQ + 64'd1;
            engLeftD = holdLeftQ - 8'd1;
            if (!srcLastBeat) engStateD = EngBurst;
          end else begin
            engWordD  = holdWordQ;
            engLeftD  = holdLeftQ;
            engStateD = EngBurst;
          end
        end
      end
      EngBurst: begin
        if (issue) begin
          if (srcLastBeat) begin
            if (holdValidQ) begin
              holdTake    = 1'b1;
              engIdD      = holdIdQ;
              engWordD    = holdWordQ;
              engLeftD    = holdLeftQ;
              engSizeErrD = holdSizeErrQ;
            end else begin
              engStateD = EngIdle;
            end
          end else begin
            engWordD = engWordQ + 64'd1;
            engLeftD = engLeftQ - 8'd1;
          end
        end
      end
      default: engStateD = EngIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      engStateQ <= EngIdle;
    end else begin
      engStateQ <= engStateD;
    end
    engIdQ      <= engIdD;
    engWordQ    <= engWordD;
    engLeftQ    <= engLeftD;
    engSizeErrQ <= engSizeErrD;
  end

  // Write and read in the same cycle to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (memWriteEnable) mem[memWriteAddr] <= memWriteData;
    if (issue) aDataQ <= mem[srcWord[MemIndexSize-1:0]];
  end

  assign aAdvance = aValidQ & ~skidValidQ;
  assign inData   = aErrQ ? '0 : aDataQ;
  assign inResp   = aErrQ ? 2'b10 : 2'b00;

  always_ff @(posedge clk) begin
    if (srst) begin
      aValidQ <= 1'b0;
    end else if (issue) begin
      aValidQ <= 1'b1;
    end else if (aAdvance) begin
      aValidQ <= 1'b0;
    end
    if (issue) begin
      aIdQ   <= srcId;
      aErrQ  <= srcSizeErr | srcRangeErr;
      aLastQ <= srcLastBeat;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      outValidQ  <= 1'b0;
      outIdQ     <= '0;
      outDataQ   <= '0;
      outRespQ   <= 2'b00;
      outLastQ   <= 1'b0;
      skidValidQ <= 1'b0;
    end else if (!outValidQ || axiRReady) begin
      if (skidValidQ) begin
        outValidQ  <= 1'b1;
        outIdQ     <= skidIdQ;
        outDataQ   <= skidDataQ;
        outRespQ   <= skidRespQ;
        outLastQ   <= skidLastQ;
        skidValidQ <= 1'b0;
      end else begin
        outValidQ <= aAdvance;
        if (aAdvance) begin
          outIdQ   <= aIdQ;
          outDataQ <= inData;
          outRespQ <= inResp;
          outLastQ <= aLastQ;
        end
      end
    end else if (aAdvance) begin
      skidValidQ <= 1'b1;
      skidIdQ    <= aIdQ;
      skidDataQ  <= inData;
      skidRespQ  <= inResp;
      skidLastQ  <= aLastQ;
    end
  end

  assign axiRValid = outValidQ;
  assign axiRId    = outIdQ;
  assign axiRData  = outDataQ;
  assign axiRResp  = outRespQ;
  assign axiRLast  = outLastQ;

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI-4 read slave backed by an internal word-addressed RAM. It accepts AR requests, returns INCR bursts on the R channel and flags bad accesses with SLVERR.
- Serves as the downstream responder for the SMI-to-AXI read adaptor, both in simulation benches and as an on-chip scratch memory.
- A side write port preloads and updates RAM contents.
- One clock, single in-order response stream.

Parameters:
- DataIndexSize, 4, log2 of bytes per data word; DataWidth = (1 << DataIndexSize) * 8.
- AxiIdWidth, 4, width of the AR/R ID fields.
- MemIndexSize, 10, log2 of RAM depth in words.

Ports:
- clk  in  1  system clock.
- srst  in  1  reset; one clock, synchronous, active-high.
- axiARValid  in  1  read address valid.
- axiARReady  out  1  read address ready.
- axiARId  in  AxiIdWidth  transaction ID.
- axiARAddr  in  64  byte address.
- axiARLen  in  8  burst length minus 1.
- axiARSize  in  3  beat size code.
- axiRValid  out  1  read data valid.
- axiRReady  in  1  read data ready.
- axiRId  out  AxiIdWidth  echoed transaction ID.
- axiRData  out  DataWidth  read data.
- axiRResp  out  2  00 OKAY, 10 SLVERR.
- axiRLast  out  1  final beat of burst.
- memWriteEnable  in  1  preload write strobe.
- memWriteAddr  in  MemIndexSize  preload word index.
- memWriteData  in  DataWidth  preload data.

Behaviour:
- Reset values while srst is high:
  - axiARReady=0, axiRValid=0, axiRLast=0, axiRResp=00, axiRId=0.
  - All pending and active bursts are discarded; RAM contents are retained.
  - axiARReady rises the cycle after srst deasserts.
- AR acceptance:
  - A handshake occurs when axiARValid & axiARReady at a clock edge.
  - One holding register: axiARReady=1 exactly when the holding register is empty.
  - The holding register moves to the active burst engine when the engine is idle, or on the cycle the engine issues its last beat.
- Burst engine:
  - Per burst it latches ID, base word = axiARAddr >> DataIndexSize, beat count = axiARLen+1 (1..256), and error flags.
  - Unaligned addresses return the containing aligned word for the first beat; later beats increment by one word.
- Errors:
  - sizeErr = (axiARSize != DataIndexSize).
  - rangeErr per beat = beat word index (64-bit arithmetic) >= 2^MemIndexSize.
  - Any error beat returns axiRResp=10 and axiRData=0. Other beats return OKAY and RAM data.
  - A burst that crosses the end of the RAM gives OKAY beats first, then SLVERR beats. No wrap-around.
- Latency:
  - With the engine idle and axiRReady=1, the first axiRValid is asserted exactly 2 cycles after the AR handshake.
  - Beats issue every cycle while axiRReady=1.
  - Back-to-back bursts have zero bubble cycles when the next AR was already held.
- R handshake:
  - Once asserted, axiRValid stays high and axiRId/Data/Resp/Last stay stable until axiRReady.
  - A beat completes on axiRValid & axiRReady.
  - A skid stage absorbs the RAM read pipeline so no beat is lost or duplicated under arbitrary axiRReady toggling.
- axiRLast=1 only on beat count-1. A single-beat burst (len 0) has axiRLast on its only beat.
- Ordering: responses are strictly in AR acceptance order; IDs are echoed unchanged.
- Preload port:
  - A write updates the RAM at the clock edge.
  - A read of the same word scheduled in the same cycle returns the old data.
  - Later reads return the new data.
- Reset mid-burst: axiRValid drops the cycle srst is sampled high, and no remaining beats of that burst are ever issued.

Test Plan:
1. Preload words 0..7 with value = index. AR id=3, addr=0x20, len=3, size=4 -> axiRValid 2 cycles after handshake; data 2,3,4,5; resp 00; id 3; axiRLast on 4th beat only.
2. AR addr=0x25 (unaligned), len=0 -> single beat with data of word 2, axiRLast=1, OKAY.
3. MemIndexSize=10, AR addr=(1022<<4), len=3 -> beats 1022,1023 OKAY with RAM data; beats 3 and 4 SLVERR with data 0; axiRLast on beat 4.
4. Two ARs back-to-back (id 1 len 1, id 2 len 2) with axiRReady=1 -> 5 consecutive beats, no gap, ids 1,1,2,2,2. A third AR is held off (axiARReady=0) until the holding register frees.
5. AR len=15 with axiRReady random 50% -> exactly 16 beats in order, with data/resp/last stable during every stall cycle.
6. Assert srst during beat 3 of a len=7 burst -> axiRValid=0 next cycle, no further beats. A new AR after reset returns correct data from the preloaded RAM.
